// File: rtl/cpu6502_pkg.sv
// Shared types for the 6502 front end: address/byte aliases, prefetch queue
// entry layout and the fetch-state encoding.
package cpu6502_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  byte_t;

  typedef struct packed {
    addr_t pc;
    byte_t data;
  } fq_entry_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FULL  = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/byte_fifo.sv
// DEPTH-entry circular buffer of {pc, byte} entries with push, pop, flush and
// an occupancy count. Flush wins over push/pop in the same cycle.
module byte_fifo
  import cpu6502_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fq_entry_t              push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output fq_entry_t              head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  fq_entry_t     mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q,  count_d;

  // DEPTH is a power of two, so pointer wrap is plain PW-bit overflow.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are never visible while count is 0.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch: walks the byte ROM from the fetch PC, buffers bytes with
// their PCs, and hands them to the decoder; redirect flushes and restarts fetch.
module fetch_prefetch_queue
  import cpu6502_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter addr_t RESET_PC = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [15:0]            mem_addr,
  input  logic [7:0]             mem_data,
  input  logic                   redirect_valid,
  input  logic [15:0]            redirect_pc,
  output logic                   out_valid,
  output logic [7:0]             out_byte,
  output logic [15:0]            out_pc,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fill_level
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  fetch_state_t state_q, state_d;
  addr_t        fpc_q, fpc_d;
  logic [PW:0]  count;
  fq_entry_t    head;
  logic         pop, push;

  assign pop  = out_valid && out_ready;
  assign push = (state_q != S_FLUSH) && !redirect_valid &&
                ((count != FULL_CNT) || pop);

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry ('{pc: fpc_q, data: mem_data}),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (count)
  );

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    if (redirect_valid) begin
      state_d = S_FLUSH;
      fpc_d   = redirect_pc;
    end else begin
      if (push) fpc_d = fpc_q + 16'd1;
      unique case (state_q)
        S_RUN:   if ((count == FULL_CNT || (count == FULL_CNT - 1'b1 && push)) && !pop)
                   state_d = S_FULL;
        S_FULL:  if (pop) state_d = S_RUN;
        S_FLUSH: state_d = S_RUN;
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      fpc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
    end
  end

  // Head fields read as zero while empty so reset and flush show clean outputs.
  assign mem_addr   = fpc_q;
  assign out_valid  = (count != '0);
  assign out_byte   = out_valid ? head.data : 8'h00;
  assign out_pc     = out_valid ? head.pc   : 16'h0000;
  assign fill_level = count;

endmodule
